crc32_frame_arbiter: RTL and testbench

Frame-level scheduler that shares one combinational crc_16 step instance (CRC-32, reflected, poly 0xEDB88320, 16-bit input) between NUM_CH streaming requesters.
- Grants one requester for a whole frame and seeds the CRC register.
- Steps the CRC once per accepted 16-bit word.
- On the last word, applies the output XOR and presents the result on a single result channel tagged with the channel index and word count.
- Sits between packet sources (e.g. MAC TX/RX paths) and the FCS insert/check logic.

---
 rtl/crc32_frame_arbiter.sv | 177 +++++++++++++++++
 tb/tb_crc32_frame_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_frame_arbiter.sv
// crc32_frame_arbiter
// Frame-level scheduler that shares one 16-bit-per-step CRC-32 datapath
// (reflected, poly 0xEDB88320) between NUM_CH streaming requesters.
// A requester is granted for a whole frame. Each accepted word steps the
// CRC register once. On the last word the finished CRC, the channel index
// and the word count are presented on a single result channel.
//
// Handshake rule, used by both the input lanes and the result channel:
// a transfer happens on the rising clk_i edge at which valid and ready are
// both high. valid, once raised, is held with stable payload until that
// edge. ready may be asserted without valid being present.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous, active-high reset
//   s_valid_i    per-channel word valid                       [NUM_CH]
//   s_ready_o    per-channel word ready, at most one bit set  [NUM_CH]
//   s_data_i     per-channel word, channel k at [16k+15:16k]; bit 0 is
//                sent first on the wire and the low byte is the first byte
//   s_last_i     per-channel last-word flag, qualified by valid&ready
//   m_valid_o    result valid
//   m_ready_i    result accepted
//   m_crc_o      final CRC (register ^ CRC_XOROUT)
//   m_ch_o       channel index of the result
//   m_words_o    words in the frame, saturating at 16'hFFFF
//   dbg_state_o  FSM state (0 IDLE, 1 RUN, 2 RESULT)
module crc32_frame_arbiter #(
  parameter int          NUM_CH     = 2,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH-1:0]      s_valid_i,
  output logic [NUM_CH-1:0]      s_ready_o,
  input  logic [16*NUM_CH-1:0]   s_data_i,
  input  logic [NUM_CH-1:0]      s_last_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [31:0]            m_crc_o,
  output logic [2:0]             m_ch_o,
  output logic [15:0]            m_words_o,
  output logic [1:0]             dbg_state_o
);

  localparam logic [31:0]       POLY    = 32'hEDB88320;
  localparam logic [NUM_CH-1:0] ONE_HOT = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]            grant;
  logic [2:0]            rr_ptr;
  logic [2:0]            arb_sel;
  logic                  arb_hit;
  logic [3:0]            arb_idx;
  logic [NUM_CH-1:0]     arb_vsh;
  logic [31:0]           crc_reg;
  logic [31:0]           crc_step;
  logic [15:0]           word_cnt;
  logic [15:0]           cnt_inc;
  logic [NUM_CH-1:0]     valid_sh;
  logic [NUM_CH-1:0]     last_sh;
  logic [16*NUM_CH-1:0]  data_sh;
  logic                  g_valid;
  logic                  g_last;
  logic [15:0]           g_data;
  logic                  accept;

  // One CRC step over a 16-bit word, LSB first: the low byte goes out first,
  // which is the same as running the bytewise reflected CRC low byte first.
  function automatic logic [31:0] crc_16(input logic [31:0] c, input logic [15:0] d);
    logic [31:0] r;
    r = c ^ {16'h0000, d};
    for (int i = 0; i < 16; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Select the granted lane with shifts. This avoids indexing a narrow
  // vector with the 3-bit grant.
  assign valid_sh = s_valid_i >> grant;
  assign last_sh  = s_last_i >> grant;
  assign data_sh  = s_data_i >> {grant, 4'b0000};
  assign g_valid  = valid_sh[0];
  assign g_last   = last_sh[0];
  assign g_data   = data_sh[15:0];

  assign accept   = (state == RUN) && g_valid;
  assign crc_step = crc_16(crc_reg, g_data);
  assign cnt_inc  = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

  // Round-robin search: first requester at or after rr_ptr, modulo NUM_CH.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = '0;
    arb_idx = '0;
    arb_vsh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_idx = {1'b0, rr_ptr} + 4'(i);
      if (arb_idx >= 4'(NUM_CH)) arb_idx = arb_idx - 4'(NUM_CH);
      arb_vsh = s_valid_i >> arb_idx;
      if (!arb_hit && arb_vsh[0]) begin
        arb_hit = 1'b1;
        arb_sel = arb_idx[2:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready_o = '0;
    case (state)
      IDLE:   if (arb_hit) state_nxt = RUN;
      RUN: begin
        s_ready_o = ONE_HOT << grant;
        if (accept && g_last) state_nxt = RESULT;
      end
      RESULT: if (m_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant     <= '0;
      rr_ptr    <= '0;
      crc_reg   <= CRC_INIT;
      word_cnt  <= '0;
      m_valid_o <= 1'b0;
      m_crc_o   <= '0;
      m_ch_o    <= '0;
      m_words_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            grant    <= arb_sel;
            crc_reg  <= CRC_INIT;
            word_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            crc_reg  <= crc_step;
            word_cnt <= cnt_inc;
            if (g_last) begin
              m_crc_o   <= crc_step ^ CRC_XOROUT;
              m_words_o <= cnt_inc;
              m_ch_o    <= grant;
              m_valid_o <= 1'b1;
              rr_ptr    <= (grant == 3'(NUM_CH - 1)) ? 3'd0 : grant + 3'd1;
            end
          end
        end
        RESULT: begin
          if (m_ready_i) m_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_frame_arbiter.sv
module tb_crc32_frame_arbiter;

  localparam int          NUM_CH = 3;
  localparam logic [31:0] INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] XOROUT = 32'hFFFFFFFF;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_RESULT = 2'd2;

  logic                  clk_i;
  logic                  rst_i;
  logic [NUM_CH-1:0]     s_valid_i;
  logic [NUM_CH-1:0]     s_ready_o;
  logic [16*NUM_CH-1:0]  s_data_i;
  logic [NUM_CH-1:0]     s_last_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [31:0]           m_crc_o;
  logic [2:0]            m_ch_o;
  logic [15:0]           m_words_o;
  logic [1:0]            dbg_state_o;

  logic        s_valid_a [NUM_CH];
  logic        s_last_a  [NUM_CH];
  logic [15:0] s_data_a  [NUM_CH];

  crc32_frame_arbiter #(.NUM_CH(NUM_CH), .CRC_INIT(INIT), .CRC_XOROUT(XOROUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_crc_o(m_crc_o), .m_ch_o(m_ch_o),
    .m_words_o(m_words_o), .dbg_state_o(dbg_state_o)
  );

  always_comb begin
    s_valid_i = '0;
    s_last_i  = '0;
    s_data_i  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s_valid_i[k]         = s_valid_a[k];
      s_last_i[k]          = s_last_a[k];
      s_data_i[16*k +: 16] = s_data_a[k];
    end
  end

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [17:0] feed_q [NUM_CH][$];   // {hole, last, word}
  logic [31:0] mcrc   [NUM_CH];
  int          mwords [NUM_CH];
  logic [47:0] ch_exp [NUM_CH][$];   // {words, crc}
  logic [50:0] exp_q[$];             // {ch, words, crc}
  int          model_rr = 0;
  int          max_ones = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: classic bytewise reflected CRC-32, one byte at a time.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      mcrc[k]   = INIT;
      mwords[k] = 0;
      feed_q[k].delete();
      ch_exp[k].delete();
    end
    exp_q.delete();
    model_rr = 0;
  endtask

  task automatic push_word(input int ch, input logic [15:0] w, input logic last);
    logic [15:0] w16;
    feed_q[ch].push_back({1'b0, last, w});
    mcrc[ch] = crc_byte(crc_byte(mcrc[ch], w[7:0]), w[15:8]);
    mwords[ch]++;
    if (last) begin
      w16 = (mwords[ch] > 65535) ? 16'hFFFF : 16'(mwords[ch]);
      ch_exp[ch].push_back({w16, mcrc[ch] ^ XOROUT});
      mcrc[ch]   = INIT;
      mwords[ch] = 0;
    end
  endtask

  task automatic push_hole(input int ch);
    feed_q[ch].push_back({1'b1, 1'b0, 16'h0000});
  endtask

  // Result order: round robin over channels that have whole frames queued.
  task automatic plan();
    bit any, found;
    int c;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        c = (model_rr + i) % NUM_CH;
        if (!found && ch_exp[c].size() > 0) begin
          exp_q.push_back({3'(c), ch_exp[c].pop_front()});
          model_rr = (c + 1) % NUM_CH;
          found = 1'b1;
        end
      end
      for (int k = 0; k < NUM_CH; k++) if (ch_exp[k].size() > 0) any = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_ch(input int ch);
    logic [17:0] e;
    int          n;
    bit          ok;
    while (feed_q[ch].size() > 0) begin
      e = feed_q[ch].pop_front();
      if (e[17]) begin
        s_valid_a[ch] = 1'b0;
        step();
      end else begin
        s_valid_a[ch] = 1'b1;
        s_data_a[ch]  = e[15:0];
        s_last_a[ch]  = e[16];
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 2000) begin
          @(negedge clk_i);
          if (s_ready_o[ch]) ok = 1'b1;
          n++;
        end
        if (!ok) chk($sformatf("drive_wait_ch%0d", ch), 64'(ok), 64'd1);
        step();
      end
    end
    s_valid_a[ch] = 1'b0;
    s_last_a[ch]  = 1'b0;
  endtask

  task automatic check_entry(input string tag);
    logic [50:0] e;
    chk({tag, "_sb"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_ch"},    64'(m_ch_o),    64'(e[50:48]));
      chk({tag, "_words"}, 64'(m_words_o), 64'(e[47:32]));
      chk({tag, "_crc"},   64'(m_crc_o),   64'(e[31:0]));
    end
  endtask

  task automatic check_result(input string tag, output int waited);
    waited = 0;
    @(negedge clk_i);
    while (!m_valid_o && waited < 300) begin
      waited++;
      @(negedge clk_i);
    end
    chk({tag, "_valid"}, 64'(m_valid_o), 64'd1);
    check_entry(tag);
  endtask

  task automatic collect(input int n, input bit rnd_ready);
    int got, cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 5000) begin
      step();
      m_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk_i);
      if ($countones(s_ready_o) > max_ones) max_ones = $countones(s_ready_o);
      if (m_valid_o && m_ready_i) begin
        check_entry($sformatf("res%0d", got));
        got++;
      end
      cyc++;
    end
    chk("collect_count", 64'(got), 64'(n));
    m_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    m_ready_i = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      s_valid_a[k] = 1'b0;
      s_last_a[k]  = 1'b0;
      s_data_a[k]  = 16'h0000;
    end
    model_reset();
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic push_12345678(input int ch, input int gap);
    push_word(ch, 16'h3231, 1'b0);
    push_word(ch, 16'h3433, 1'b0);
    for (int g = 0; g < gap; g++) push_hole(ch);
    push_word(ch, 16'h3635, 1'b0);
    push_word(ch, 16'h3837, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [50:0] held;
  int          waited;
  int          nfr;
  int          len;

  initial begin
    rst_i     = 1'b1;
    m_ready_i = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      s_valid_a[k] = 1'b0;
      s_last_a[k]  = 1'b0;
      s_data_a[k]  = 16'h0000;
    end
    model_reset();

    // reset values
    @(negedge clk_i);
    chk("rst_ready", 64'(s_ready_o), 64'd0);
    chk("rst_valid", 64'(m_valid_o), 64'd0);
    chk("rst_crc",   64'(m_crc_o),   64'd0);
    chk("rst_ch",    64'(m_ch_o),    64'd0);
    chk("rst_words", 64'(m_words_o), 64'd0);
    chk("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
    do_reset();

    // "12345678" on ch0, result one clk after the last word
    push_12345678(0, 0);
    plan();
    drive_ch(0);
    check_result("t1", waited);
    chk("t1_latency", 64'(waited), 64'd0);
    chk("t1_const", 64'(m_crc_o), 64'h9AE0DAAF);
    step();
    @(negedge clk_i);
    chk("t1_drop", 64'(m_valid_o), 64'd0);
    step();

    // ch1 single zero word, then a two-word zero frame
    push_word(1, 16'h0000, 1'b1);
    plan();
    drive_ch(1);
    check_result("t2a", waited);
    chk("t2a_const", 64'(m_crc_o), 64'h41D912FF);
    step();
    push_word(0, 16'h0000, 1'b0);
    push_word(0, 16'h0000, 1'b1);
    plan();
    drive_ch(0);
    check_result("t2b", waited);
    chk("t2b_const", 64'(m_crc_o), 64'h2144DF1C);
    step();

    // contention after reset: ch0 and ch1, two 2-word frames each
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 2; c++) begin
        push_word(c, 16'($urandom), 1'b0);
        push_word(c, 16'($urandom), 1'b1);
      end
    end
    plan();
    max_ones = 0;
    fork
      drive_ch(0);
      drive_ch(1);
      collect(4, 1'b0);
    join
    chk("t3_onehot", 64'(max_ones <= 1), 64'd1);
    step();

    // ch0 frame with a 3-cycle valid gap between words 2 and 3
    push_12345678(0, 3);
    plan();
    drive_ch(0);
    check_result("t4", waited);
    chk("t4_const", 64'(m_crc_o), 64'h9AE0DAAF);
    step();

    // backpressure: result held 5 clks, pending ch1 must wait
    m_ready_i = 1'b0;
    for (int w = 0; w < 3; w++) push_word(0, 16'($urandom), w == 2);
    plan();
    held = exp_q[0];
    push_word(1, 16'($urandom), 1'b0);
    push_word(1, 16'($urandom), 1'b1);
    plan();
    drive_ch(0);
    fork
      drive_ch(1);
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk_i);
          chk("t5_valid", 64'(m_valid_o), 64'd1);
          chk("t5_crc",   64'(m_crc_o),   64'(held[31:0]));
          chk("t5_ch",    64'(m_ch_o),    64'(held[50:48]));
          chk("t5_words", 64'(m_words_o), 64'(held[47:32]));
          chk("t5_ready", 64'(s_ready_o), 64'd0);
          chk("t5_state", 64'(dbg_state_o), 64'(ST_RESULT));
        end
        step();
        m_ready_i = 1'b1;
        check_result("t5a", waited);
        step();
        @(negedge clk_i);
        chk("t5_idle",      64'(dbg_state_o), 64'(ST_IDLE));
        chk("t5_idle_rdy",  64'(s_ready_o), 64'd0);
        chk("t5_idle_val",  64'(m_valid_o), 64'd0);
        step();
        @(negedge clk_i);
        chk("t5_grant_ch1", 64'(s_ready_o), 64'b010);
      end
    join
    check_result("t5b", waited);
    step();

    // asynchronous reset after word 2 of a ch0 frame
    push_word(0, 16'h3231, 1'b0);
    push_word(0, 16'h3433, 1'b0);
    drive_ch(0);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_ready", 64'(s_ready_o), 64'd0);
    chk("t6_valid", 64'(m_valid_o), 64'd0);
    chk("t6_crc",   64'(m_crc_o),   64'd0);
    chk("t6_ch",    64'(m_ch_o),    64'd0);
    chk("t6_words", 64'(m_words_o), 64'd0);
    chk("t6_state", 64'(dbg_state_o), 64'(ST_IDLE));
    model_reset();
    step();
    rst_i = 1'b0;
    push_12345678(0, 0);
    plan();
    drive_ch(0);
    check_result("t6", waited);
    chk("t6_const", 64'(m_crc_o), 64'h9AE0DAAF);
    step();

    // random frames on all channels with gaps and random result backpressure
    nfr = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        len = $urandom_range(1, 6);
        for (int w = 0; w < len; w++) begin
          push_word(c, 16'($urandom), w == len - 1);
          if (w != len - 1 && $urandom_range(0, 3) == 0) begin
            for (int g = 0; g < int'($urandom_range(1, 2)); g++) push_hole(c);
          end
        end
        nfr++;
      end
    end
    plan();
    max_ones = 0;
    fork
      drive_ch(0);
      drive_ch(1);
      drive_ch(2);
      collect(nfr, 1'b1);
    join
    chk("t7_onehot", 64'(max_ones <= 1), 64'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
